// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmit and receive blocks.
package uart_pkg;

  localparam int unsigned DATA_BITS         = 8;
  localparam int unsigned UART_CLKS_PER_BIT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: wraps every CLKS_PER_BIT cycles, flags the last cycle of each bit.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_restart,
  output logic o_tick_c
);

  localparam int unsigned           CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]      LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;

  // Count 0..CLKS_PER_BIT-1; a restart realigns the bit period to the next edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_restart || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_tick_c = (r_cnt == LAST);

endmodule

// File: rtl/uart_transmitter.sv
// UART transmit stage: four-phase REQ/ACK byte intake, start + 8 data LSB-first + stop bit(s).
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 XMIT_REQ,
  input  logic [DATA_BITS-1:0] XMIT_DATA,
  output logic                 XMIT_ACK,
  output logic                 XMIT,
  output logic                 XMIT_BUSY
);

  localparam int unsigned BIT_W     = 3;
  localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

  uart_state_t          r_state,   w_state_next;
  logic [DATA_BITS-1:0] r_shift,   w_shift_next;
  logic [BIT_W-1:0]     r_bit_cnt, w_bit_cnt_next;
  logic                 r_ack,     w_ack_next;
  logic                 r_busy,    w_busy_next;
  logic                 r_xmit,    w_xmit_next;
  logic                 w_tick;
  logic                 w_accept;

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk       (clk),
    .rst       (clr),
    .i_restart (w_accept),
    .o_tick_c  (w_tick)
  );

  // State and datapath registers; the line idles high through reset.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_ack     <= 1'b0;
      r_busy    <= 1'b0;
      r_xmit    <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_shift   <= w_shift_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_ack     <= w_ack_next;
      r_busy    <= w_busy_next;
      r_xmit    <= w_xmit_next;
    end
  end

  // Next-state, byte accept and registered line level.
  always_comb begin
    w_state_next   = r_state;
    w_shift_next   = r_shift;
    w_bit_cnt_next = r_bit_cnt;
    w_busy_next    = r_busy;
    w_accept       = 1'b0;
    w_xmit_next    = 1'b1;

    case (r_state)
      IDLE: begin
        if (XMIT_REQ && !r_ack) w_accept = 1'b1;
      end
      START: begin
        if (w_tick) begin
          w_state_next   = DATA;
          w_bit_cnt_next = '0;
        end
      end
      DATA: begin
        if (w_tick) begin
          if (r_bit_cnt == LAST_DATA) begin
            w_state_next   = STOP;
            w_bit_cnt_next = '0;
          end else begin
            w_shift_next   = r_shift >> 1;
            w_bit_cnt_next = r_bit_cnt + BIT_W'(1);
          end
        end
      end
      STOP: begin
        if (w_tick) begin
          if (r_bit_cnt == LAST_STOP) begin
            if (XMIT_REQ && !r_ack) begin
              w_accept = 1'b1;
            end else begin
              w_state_next = IDLE;
              w_busy_next  = 1'b0;
            end
          end else begin
            w_bit_cnt_next = r_bit_cnt + BIT_W'(1);
          end
        end
      end
      default: begin
        w_state_next = IDLE;
        w_busy_next  = 1'b0;
      end
    endcase

    // Accept overrides the per-state update: load the byte and restart the frame.
    if (w_accept) begin
      w_state_next   = START;
      w_shift_next   = XMIT_DATA;
      w_bit_cnt_next = '0;
      w_busy_next    = 1'b1;
    end

    if (w_accept)       w_ack_next = 1'b1;
    else if (!XMIT_REQ) w_ack_next = 1'b0;
    else                w_ack_next = r_ack;

    case (w_state_next)
      START:   w_xmit_next = 1'b0;
      DATA:    w_xmit_next = w_shift_next[0];
      default: w_xmit_next = 1'b1;
    endcase
  end

  assign XMIT_ACK  = r_ack;
  assign XMIT_BUSY = r_busy;
  assign XMIT      = r_xmit;

endmodule
